// File: rtl/tff_toggle_seq_if.sv
// tff_toggle_seq_if: control/config inputs and toggle-train outputs of the TFF driver
interface tff_toggle_seq_if #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
);
  logic               start;
  logic               stop;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   divisor;
  logic [BURST_W-1:0] burst_len;
  logic               t;
  logic               busy;
  logic               done;
  logic               q_model;
  logic [BURST_W-1:0] toggle_count;
  modport master (
    output start, stop, mode, divisor, burst_len,
    input  t, busy, done, q_model, toggle_count
  );
  modport slave (
    input  start, stop, mode, divisor, burst_len,
    output t, busy, done, q_model, toggle_count
  );
endinterface

// File: rtl/tff_toggle_seq.sv
// tff_toggle_seq: periodic 1-cycle toggle-request generator (single/burst/continuous) with Q reference model
module tff_toggle_seq #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input logic CLK,
  input logic CLEAR,
  tff_toggle_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   pre_q, pre_d, div_q, div_d;
  logic [BURST_W-1:0] n_q, n_d, iss_q, iss_d, cnt_q, cnt_d;
  logic               cont_q, cont_d, t_q, t_d, q_q, q_d, last;
  always_ff @(posedge CLK) begin
    if (!CLEAR) begin
      state_q <= IDLE;
      pre_q   <= '0;
      div_q   <= '0;
      n_q     <= '0;
      iss_q   <= '0;
      cnt_q   <= '0;
      cont_q  <= 1'b0;
      t_q     <= 1'b0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      div_q   <= div_d;
      n_q     <= n_d;
      iss_q   <= iss_d;
      cnt_q   <= cnt_d;
      cont_q  <= cont_d;
      t_q     <= t_d;
      q_q     <= q_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    div_d   = div_q;
    n_d     = n_q;
    iss_d   = iss_q;
    cnt_d   = cnt_q;
    cont_d  = cont_q;
    t_d     = 1'b0;
    q_d     = q_q;
    last    = 1'b0;
    case (state_q)
      IDLE: if (bus.start && bus.mode != 2'b11) begin
        state_d = RUN;
        div_d   = (bus.divisor == '0) ? CNT_W'(1) : bus.divisor;
        pre_d   = div_d - 1'b1;
        iss_d   = '0;
        cnt_d   = '0;
        cont_d  = bus.mode == 2'b10;
        n_d     = (bus.mode == 2'b01) ? bus.burst_len : BURST_W'(1);
      end
      RUN: begin
        t_d   = pre_q == '0 && (cont_q || iss_q < n_q);
        pre_d = (pre_q == '0) ? div_q - 1'b1 : pre_q - 1'b1;
        iss_d = t_d ? iss_q + 1'b1 : iss_q;
        q_d   = q_q ^ t_q;
        cnt_d = t_q ? cnt_q + 1'b1 : cnt_q;
        // a zero-length burst finishes on the first RUN edge without pulsing
        last  = !cont_q && ((t_q && cnt_d == n_q) || n_q == '0);
        if (bus.stop || last) begin
          state_d = DONE;
          t_d     = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.t            = t_q;
  assign bus.busy         = state_q == RUN;
  assign bus.done         = state_q == DONE;
  assign bus.q_model      = q_q;
  assign bus.toggle_count = cnt_q;
endmodule

// File: tb/tb_tff_toggle_seq.sv
// tb_tff_toggle_seq: directed-vector bench for the toggle-request sequencer
module tb_tff_toggle_seq;
  logic CLK = 1'b0;
  logic CLEAR = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic q_exp = 1'b0;
  tff_toggle_seq_if #(.CNT_W(8), .BURST_W(8)) bus ();
  tff_toggle_seq #(.CNT_W(8), .BURST_W(8)) dut (.CLK(CLK), .CLEAR(CLEAR), .bus(bus));
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input logic [7:0] d, input logic [7:0] n);
    bus.mode = m;
    bus.divisor = d;
    bus.burst_len = n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'b00; bus.divisor = '0; bus.burst_len = '0;
    CLEAR = 1'b0;
    tick(); tick();
    vectors++;
    if ({bus.t, bus.busy, bus.done, bus.q_model, bus.toggle_count} !== 12'h0) begin
      miscompares++;
      $display("FAIL por_outputs got=%h exp=0", {bus.t, bus.busy, bus.done, bus.q_model, bus.toggle_count});
    end
    CLEAR = 1'b1;
    launch(2'b01, 8'd2, 8'd5);
    tick(); tick(); tick();
    vectors++;
    if (bus.q_model !== 1'b1 || bus.toggle_count !== 8'd1) begin
      miscompares++;
      $display("FAIL pre_reset_state q=%b cnt=%0d exp q=1 cnt=1", bus.q_model, bus.toggle_count);
    end
    tick();
    vectors++;
    if (bus.t !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_t got=%b exp=1", bus.t);
    end
    CLEAR = 1'b0;
    tick(); tick();
    CLEAR = 1'b1;
    vectors++;
    if ({bus.t, bus.busy, bus.done, bus.q_model, bus.toggle_count} !== 12'h0) begin
      miscompares++;
      $display("FAIL midburst_reset got=%h exp=0", {bus.t, bus.busy, bus.done, bus.q_model, bus.toggle_count});
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (bus.t !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_quiet[%0d] t=%b busy=%b done=%b exp 0", i, bus.t, bus.busy, bus.done);
      end
    end
    q_exp = 1'b0;
  endtask

  task automatic test_burst();
    launch(2'b01, 8'd3, 8'd2);
    vectors++;
    if (bus.busy !== 1'b1 || bus.toggle_count !== 8'd0) begin
      miscompares++;
      $display("FAIL burst_accept busy=%b cnt=%0d exp busy=1 cnt=0", bus.busy, bus.toggle_count);
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 4 || e == 7) q_exp = ~q_exp;
      vectors++;
      if (bus.t !== (e == 3 || e == 6) || bus.done !== (e == 7) || bus.busy !== (e < 7)
          || bus.q_model !== q_exp) begin
        miscompares++;
        $display("FAIL burst_edge%0d t=%b done=%b busy=%b q=%b exp t=%b done=%b busy=%b q=%b",
                 e, bus.t, bus.done, bus.busy, bus.q_model, e == 3 || e == 6, e == 7, e < 7, q_exp);
      end
      if (e == 7) begin
        vectors++;
        if (bus.toggle_count !== 8'd2) begin
          miscompares++;
          $display("FAIL burst_count got=%0d exp=2", bus.toggle_count);
        end
      end
    end
  endtask

  task automatic test_single();
    launch(2'b00, 8'd0, 8'd9);
    for (int e = 1; e <= 3; e++) begin
      tick();
      if (e == 2) q_exp = ~q_exp;
      vectors++;
      if (bus.t !== (e == 1) || bus.done !== (e == 2) || bus.q_model !== q_exp) begin
        miscompares++;
        $display("FAIL single_edge%0d t=%b done=%b q=%b exp t=%b done=%b q=%b",
                 e, bus.t, bus.done, bus.q_model, e == 1, e == 2, q_exp);
      end
    end
    vectors++;
    if (bus.toggle_count !== 8'd1) begin
      miscompares++;
      $display("FAIL single_count got=%0d exp=1", bus.toggle_count);
    end
  endtask

  task automatic test_continuous();
    logic [7:0] c;
    launch(2'b10, 8'd1, 8'd0);
    for (int e = 1; e <= 300; e++) begin
      tick();
      c = 8'(e - 1);
      vectors++;
      if (bus.t !== 1'b1 || bus.busy !== 1'b1 || bus.toggle_count !== c) begin
        miscompares++;
        $display("FAIL cont_edge%0d t=%b busy=%b cnt=%0d exp t=1 busy=1 cnt=%0d",
                 e, bus.t, bus.busy, bus.toggle_count, c);
      end
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.t !== 1'b0 || bus.toggle_count !== 8'd44
        || bus.q_model !== q_exp) begin
      miscompares++;
      $display("FAIL cont_stop done=%b busy=%b t=%b cnt=%0d q=%b exp done=1 busy=0 t=0 cnt=44 q=%b",
               bus.done, bus.busy, bus.t, bus.toggle_count, bus.q_model, q_exp);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.t !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_after_stop done=%b t=%b exp 0 0", bus.done, bus.t);
    end
  endtask

  task automatic test_edge_cases();
    launch(2'b01, 8'd4, 8'd0);
    tick();
    vectors++;
    if (bus.done !== 1'b1 || bus.t !== 1'b0 || bus.busy !== 1'b0 || bus.toggle_count !== 8'd0) begin
      miscompares++;
      $display("FAIL zero_burst done=%b t=%b busy=%b cnt=%0d exp done=1 t=0 busy=0 cnt=0",
               bus.done, bus.t, bus.busy, bus.toggle_count);
    end
    tick();
    launch(2'b11, 8'd1, 8'd3);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reserved_mode busy=%b exp=0", bus.busy);
    end
    tick();
    vectors++;
    if (bus.busy !== 1'b0 || bus.t !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reserved_idle busy=%b t=%b done=%b exp 0", bus.busy, bus.t, bus.done);
    end
    bus.stop = 1'b1;
    launch(2'b00, 8'd1, 8'd0);
    bus.stop = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_stop_idle busy=%b exp=1", bus.busy);
    end
    tick(); tick();
    q_exp = ~q_exp;
    vectors++;
    if (bus.done !== 1'b1 || bus.toggle_count !== 8'd1 || bus.q_model !== q_exp) begin
      miscompares++;
      $display("FAIL start_stop_done done=%b cnt=%0d q=%b exp done=1 cnt=1 q=%b",
               bus.done, bus.toggle_count, bus.q_model, q_exp);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    launch(2'b01, 8'd2, 8'd2);
    for (int e = 1; e <= 16; e++) begin
      bus.start = (e == 2 || e == 6);
      tick();
      bus.start = 1'b0;
      if (bus.done === 1'b1) dones++;
      if (e >= 6) begin
        vectors++;
        if (bus.busy !== 1'b0 || bus.t !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_idle_edge%0d busy=%b t=%b exp 0 0", e, bus.busy, bus.t);
        end
      end
    end
    q_exp = ~q_exp; q_exp = ~q_exp;
    vectors++;
    if (dones != 1 || bus.toggle_count !== 8'd2 || bus.q_model !== q_exp) begin
      miscompares++;
      $display("FAIL b2b_summary dones=%0d cnt=%0d q=%b exp dones=1 cnt=2 q=%b",
               dones, bus.toggle_count, bus.q_model, q_exp);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_single();
    test_continuous();
    test_edge_cases();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
